ifu_fetch_buf: RTL and testbench



---
 rtl/ifu_fetch_buf.sv | 154 +++++++++++++++
 tb/tb_ifu_fetch_buf.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_buf.sv
// ifu_fetch_buf: instruction-fetch front end.
//   Generates fetch PCs, issues req/gnt transactions to instruction memory, buffers
//   in-order responses in a small circular queue and presents one instruction per
//   cycle to the ID stage. Wrong-path responses still in flight after a flush or
//   redirect are discarded by a kill counter.
// Ports:
//   clk, srst                       clock, synchronous active-high reset
//   if_stall                        ID cannot accept the head entry
//   if_flush, if_flush_force        discard queue and in-flight fetches
//   redirect_en, redirect_pc        new fetch target (also flushes)
//   imem_req/addr/gnt               request channel to instruction memory
//   imem_rvalid/rdata/err           in-order response channel
//   if_valid/pc/inst/bus_err        head entry presented to ID
module ifu_fetch_buf #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        if_stall,
    input  logic        if_flush,
    input  logic        if_flush_force,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_bus_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DepthW = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   deliver_pc_q, deliver_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] kill_q, kill_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    // Queue storage; only entries covered by count_q are ever observed, so no reset.
    logic [31:0] pc_mem_q   [DEPTH];
    logic [31:0] inst_mem_q [DEPTH];
    logic        err_mem_q  [DEPTH];

    logic        flush;
    logic        gnt_ok;
    logic        push;
    logic        pop;
    logic [CW:0] credit_used;
    logic [31:0] push_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LastPtr) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign flush       = if_flush | if_flush_force | redirect_en;
    // Credit rule: issued-but-unanswered plus buffered never exceeds DEPTH, so a
    // response always finds a free slot.
    assign credit_used = {1'b0, outst_q} + {1'b0, count_q};
    assign imem_req    = !srst && !flush && (credit_used < DepthW);
    assign imem_addr   = fetch_pc_q;

    assign gnt_ok  = imem_req & imem_gnt;
    assign push    = imem_rvalid && !flush && (kill_q == '0);
    assign pop     = if_valid && !if_stall && !flush;
    // Entries are in order, so a new entry sits count_q words past the head PC.
    assign push_pc = deliver_pc_q + {{(30 - CW){1'b0}}, count_q, 2'b00};

    assign if_valid   = (count_q != '0);
    assign if_pc      = if_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign if_bus_err = if_valid & err_mem_q[rd_ptr_q];
    assign if_inst    = (if_valid && !err_mem_q[rd_ptr_q]) ? inst_mem_q[rd_ptr_q] : 32'h0;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        deliver_pc_d = deliver_pc_q;
        count_d      = count_q;
        kill_d       = kill_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        outst_d      = outst_q + CW'(gnt_ok) - CW'(imem_rvalid);

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            // Everything still in flight belongs to the abandoned path.
            kill_d   = outst_q - CW'(imem_rvalid);
            if (redirect_en) begin
                fetch_pc_d   = {redirect_pc[31:2], 2'b00};
                deliver_pc_d = {redirect_pc[31:2], 2'b00};
            end else begin
                fetch_pc_d   = deliver_pc_q;
            end
        end else begin
            if (imem_rvalid && (kill_q != '0)) begin
                kill_d = kill_q - 1'b1;
            end
            if (gnt_ok) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d     = ptr_inc(rd_ptr_q);
                deliver_pc_d = deliver_pc_q + 32'd4;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            fetch_pc_q   <= RESET_VEC;
            deliver_pc_q <= RESET_VEC;
            count_q      <= '0;
            outst_q      <= '0;
            kill_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            deliver_pc_q <= deliver_pc_d;
            count_q      <= count_d;
            outst_q      <= outst_d;
            kill_q       <= kill_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst && push) begin
            pc_mem_q[wr_ptr_q]   <= push_pc;
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            err_mem_q[wr_ptr_q]  <= imem_err;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
module tb_ifu_fetch_buf;

    localparam logic [31:0] RV       = 32'h8000_0000;
    localparam logic [31:0] ERR_ADDR = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        if_stall = 1'b0, if_flush = 1'b0, if_flush_force = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, imem_err = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid, if_bus_err;
    logic [31:0] if_pc, if_inst;

    // Control values applied to the DUT at the next falling edge.
    logic        srst_c = 1'b1, stall_c = 1'b0, flush_c = 1'b0, force_c = 1'b0;
    logic        redir_c = 1'b0, gnt_c = 1'b0, resp_c = 1'b1, deliver_c = 1'b1;
    logic [31:0] redir_pc_c = 32'h0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_pc = RV;
    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];

    ifu_fetch_buf #(.RESET_VEC(RV), .DEPTH(4)) dut (
        .clk(clk), .srst(srst), .if_stall(if_stall), .if_flush(if_flush),
        .if_flush_force(if_flush_force), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_bus_err(if_bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One cycle: apply controls and memory response at negedge, then observe the handshake.
    task automatic tick();
        logic [31:0] a;
        @(negedge clk);
        srst           = srst_c;
        if_stall       = stall_c;
        if_flush       = flush_c;
        if_flush_force = force_c;
        redirect_en    = redir_c;
        redirect_pc    = redir_pc_c;
        imem_gnt       = gnt_c;
        if (resp_c && pend_q.size() > 0) begin
            a           = pend_q.pop_front();
            imem_rvalid = 1'b1;
            imem_err    = (a == ERR_ADDR);
            imem_rdata  = (a == ERR_ADDR) ? 32'h0BAD_0BAD : inst_of(a);
        end else begin
            imem_rvalid = 1'b0;
            imem_err    = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        if (imem_req && imem_gnt) begin
            check("grant_addr", imem_addr, model_pc);
            pend_q.push_back(imem_addr);
            if (deliver_c) exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic drain(input int n);
        gnt_c = 1'b0;
        repeat (n) tick();
    endtask

    task automatic redirect_phase(input logic [31:0] tgt, input logic [31:0] aligned,
                                  input logic coincident);
        resp_c = 1'b0; deliver_c = 1'b0; gnt_c = 1'b1;
        tick(); tick();
        gnt_c = 1'b0; resp_c = coincident; redir_c = 1'b1; redir_pc_c = tgt;
        tick();
        check("req_low_on_redirect", {31'b0, imem_req}, 32'd0);
        model_pc = aligned;
        redir_c = 1'b0; resp_c = 1'b1; deliver_c = 1'b1; gnt_c = 1'b1;
        tick();
        check("req_after_redirect", {31'b0, imem_req}, 32'd1);
        check("addr_after_redirect", imem_addr, aligned);
        repeat (3) tick();
        drain(8);
    endtask

    task automatic flush_phase(input logic use_force);
        logic [31:0] replay_pc;
        replay_pc = model_pc;
        stall_c = 1'b1; gnt_c = 1'b1; deliver_c = 1'b0;
        repeat (6) tick();
        gnt_c = 1'b0; flush_c = !use_force; force_c = use_force;
        tick();
        check("req_low_on_flush", {31'b0, imem_req}, 32'd0);
        flush_c = 1'b0; force_c = 1'b0; stall_c = 1'b0;
        model_pc = replay_pc;
        deliver_c = 1'b1; gnt_c = 1'b1;
        tick();
        check("queue_empty_after_flush", {31'b0, if_valid}, 32'd0);
        repeat (2) tick();
        drain(6);
    endtask

    // Scoreboard monitor: whenever ID takes the head entry, compare against the expected queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (if_valid === 1'b1 && !if_stall && !srst
                && !(if_flush | if_flush_force | redirect_en)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery: got pc %08h expected none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_pc", if_pc, e);
                    check("deliver_inst", if_inst, (e == ERR_ADDR) ? 32'h0 : inst_of(e));
                    check("deliver_err", {31'b0, if_bus_err}, {31'b0, e == ERR_ADDR});
                end
            end
        end
    end

    initial begin
        // Reset held for three cycles.
        repeat (3) begin
            tick();
            check("reset_req", {31'b0, imem_req}, 32'd0);
            check("reset_valid", {31'b0, if_valid}, 32'd0);
            check("reset_pc", if_pc, 32'd0);
        end

        // Free-running fetch; 0x8000_0008 faults.
        srst_c = 1'b0; gnt_c = 1'b1;
        tick();
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RV);
        for (int i = 2; i <= 6; i++) begin
            tick();
            if (i >= 3) check("stream_valid", {31'b0, if_valid}, 32'd1);
        end
        drain(4);

        // ID stalls: queue fills, requests stop, head held.
        stall_c = 1'b1; gnt_c = 1'b1;
        repeat (8) tick();
        check("full_req_low", {31'b0, imem_req}, 32'd0);
        check("stall_valid", {31'b0, if_valid}, 32'd1);
        check("stall_pc_frozen", if_pc, 32'h8000_0018);
        stall_c = 1'b0;
        drain(6);

        // Redirect with two stale fetches in flight, then one coincident with a response.
        redirect_phase(32'h0000_0103, 32'h0000_0100, 1'b0);
        redirect_phase(32'hFFFF_FFFB, 32'hFFFF_FFF8, 1'b1);

        // Plain flush replays from the discarded head.
        flush_phase(1'b0);
        flush_phase(1'b1);

        check("all_delivered", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
